first_n_of_w: RTL and testbench
===============================

Name: first_n_of_w

Overview:
- Parametrised successor to the fixed 8-of-1536 cluster finder.
- Extracts the first NCLUSTERS set bits, lowest address first, from an NVPF-bit valid-pad-flag vector. Also extracts each hit's CNT_W-bit cluster count.
- Runs iteratively on clock4x, one cluster per cycle, and publishes all slots in parallel at fixed latency.
- Adds behaviour the old block lacked: an explicit start strobe instead of a free-running phase, a found-count, an overflow flag, invalid-slot marking, and restart-on-start.
- Sits between the S-bit/VFAT front-end and the cluster packer/optical link formatter.

Parameters:
- NVPF, 1536, number of input pad flags.
- NCLUSTERS, 8, number of output cluster slots per frame.
- CNT_W, 3, width of each cluster-size count.
- ADR_W, 11, address width. Must satisfy 2**ADR_W - 1 >= NVPF; otherwise elaboration fails.

Ports:
- clock4x  in  1  fast clock; all logic on its rising edge.
- global_reset_n  in  1  asynchronous active-low reset.
- start  in  1  frame strobe; samples vpfs/cnts on the cycle it is high.
- vpfs  in  NVPF  pad valid flags.
- cnts  in  NVPF*CNT_W  per-pad cluster counts; pad i uses bits [i*CNT_W +: CNT_W].
- busy  out  1  high while a frame is being searched.
- valid  out  1  one-cycle pulse; adr/cnt/nfound/overflow are updated on this cycle.
- adr  out  NCLUSTERS*ADR_W  slot k at [k*ADR_W +: ADR_W]; slot 0 is the lowest address.
- cnt  out  NCLUSTERS*CNT_W  slot k count at [k*CNT_W +: CNT_W].
- nfound  out  $clog2(NCLUSTERS+1)  number of valid slots in this frame.
- overflow  out  1  set bits remained after NCLUSTERS were extracted.

Behaviour:
Reset (asynchronous assert, synchronous-release-safe):
- State goes to IDLE; busy=0, valid=0, nfound=0, overflow=0.
- All adr slots = INVALID, i.e. all-ones, 0x7FF at default.
- All cnt slots = 0.
- Working mask and latched counts are cleared.

State machine IDLE -> SEARCH -> PUBLISH -> IDLE:
- IDLE: on start=1, latch the mask (from vpfs) and latch cnts. Clear the slot index k and the internal found counter. Go to SEARCH; busy=1 from the next cycle.
- SEARCH: runs exactly NCLUSTERS cycles; k increments 0..NCLUSTERS-1 each cycle.
  - Mask non-zero: find lowest set index i. Write internal slot k = {i, cnts[i]}, clear mask bit i, and increment found.
  - Mask zero: write slot k = {INVALID, 0}.
  - After the last slot: overflow_int = |mask (the remaining bits); go to PUBLISH.
- PUBLISH: drive all slots, nfound and overflow to the outputs in one cycle. Pulse valid=1 and set busy=0. Return to IDLE.

Timing and output rules:
- Latency is fixed: start at cycle T gives valid at cycle T+NCLUSTERS+1. For NCLUSTERS=8, start at 0 gives valid at 9.
- Latency does not depend on the number of hits.
- Outputs hold their values between valid pulses.
- The priority encoder is combinational within one cycle. The implementation may segment it into 16-bit groups with a group-any tree, but single-cycle throughput per slot is mandatory.

Boundary conditions:
- start while busy (SEARCH or PUBLISH): abort the current frame. No valid pulse is produced for the aborted frame. Re-latch inputs and restart SEARCH at k=0. Latency counts from the new start.
- start in the PUBLISH cycle: the valid pulse for the completing frame is still produced, and the new frame begins.
- All-zero vpfs: all slots INVALID, nfound=0, overflow=0.
- Exactly NCLUSTERS hits: nfound=NCLUSTERS, overflow=0.
- Bit NVPF-1 set: reported as address NVPF-1 (1535 at default); never confused with INVALID.
- Reset mid-frame: immediate return to the reset values; no valid pulse.

Optional Feature:
- Macro TRUNCATE_CLUSTERS_EN.
- When defined: at latch time the mask becomes vpfs & ~(vpfs << 1); bit 0 is kept unchanged. Only the first pad of each contiguous run is reported, merging adjacent pads into one cluster. This adds no extra latency.
- When undefined: the raw vpfs are latched; every set bit is a separate hit.

Test Plan:
- Reset, then no start -> busy=0, valid=0, all adr slots 0x7FF, all cnt slots 0, nfound=0.
- vpfs bits {5, 100, 1535}, with cnts 3, 1, 7 at those pads; start at cycle 0 -> valid at cycle 9. Slots 0..2 = (5,3), (100,1), (1535,7); slots 3..7 = (0x7FF,0); nfound=3, overflow=0.
- vpfs bits 0..9 all set -> slots hold addresses 0..7, nfound=8, overflow=1.
  - With TRUNCATE_CLUSTERS_EN: slot 0 = address 0, slots 1..7 = INVALID, nfound=1, overflow=0.
- start at cycle 0 (bit 10 set), second start at cycle 4 (bit 20 set) -> single valid at cycle 13 with slot 0 = 20, nfound=1. No pulse at cycle 9.
- global_reset_n low at cycle 5 of a frame -> outputs immediately at reset values; no valid pulse. A fresh start after release behaves normally.
- All-zero vpfs with start -> valid at +9, nfound=0, overflow=0, all slots INVALID.

Source files
------------

// File: rtl/first_n_of_w_if.sv
// Frame-level bus of the first-N-of-W cluster finder.
// master: front-end side (drives start/vpfs/cnts, receives the published slots).
// slave : the finder itself.
interface first_n_of_w_if #(
    parameter int NVPF      = 1536,
    parameter int NCLUSTERS = 8,
    parameter int CNT_W     = 3,
    parameter int ADR_W     = 11
);
    localparam int NF_W = $clog2(NCLUSTERS + 1);

    logic                       start;
    logic [NVPF-1:0]            vpfs;
    logic [NVPF*CNT_W-1:0]      cnts;
    logic                       busy;
    logic                       valid;
    logic [NCLUSTERS*ADR_W-1:0] adr;
    logic [NCLUSTERS*CNT_W-1:0] cnt;
    logic [NF_W-1:0]            nfound;
    logic                       overflow;

    modport master (
        output start, vpfs, cnts,
        input  busy, valid, adr, cnt, nfound, overflow
    );

    modport slave (
        input  start, vpfs, cnts,
        output busy, valid, adr, cnt, nfound, overflow
    );
endinterface

// File: rtl/first_n_of_w.sv
// first_n_of_w: iterative cluster finder.
// On a start strobe the pad-flag vector and per-pad counts are latched; the
// lowest set flag is then extracted once per clock4x cycle for NCLUSTERS
// cycles, and all slots are published together with a one-cycle valid pulse.
// Start-to-valid latency is always NCLUSTERS+1 cycles regardless of hit count.
// A start while busy aborts the frame in progress and restarts on new data.
//
// Optional feature macro: TRUNCATE_CLUSTERS_EN
//   defined   -> only the first pad of each contiguous run of set flags is
//                reported (mask = vpfs & ~(vpfs << 1) at latch time).
//   undefined -> every set flag is a separate hit.
module first_n_of_w #(
    parameter int NVPF      = 1536,
    parameter int NCLUSTERS = 8,
    parameter int CNT_W     = 3,
    parameter int ADR_W     = 11
) (
    input  logic          clock4x,
    input  logic          global_reset_n,
    first_n_of_w_if.slave bus
);
    localparam int NF_W   = $clog2(NCLUSTERS + 1);
    localparam int K_W    = (NCLUSTERS > 1) ? $clog2(NCLUSTERS) : 1;
    localparam int GRP_W  = 16;
    localparam int NGRP   = (NVPF + GRP_W - 1) / GRP_W;
    localparam int GSEL_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int PAD_W  = NGRP * GRP_W;

    // All-ones address marks an empty slot; ADR_W is sized so that no real
    // pad address can reach it.
    localparam logic [ADR_W-1:0] INVALID = '1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(NCLUSTERS - 1);

    generate
        if ((2 ** ADR_W) - 1 < NVPF) begin : g_adr_w_check
            $error("first_n_of_w: ADR_W too narrow, need 2**ADR_W-1 >= NVPF");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t             state;
    logic [NVPF-1:0]    mask;
    logic [CNT_W-1:0]   cnt_lat  [NVPF];
    logic [K_W-1:0]     k;
    logic [NF_W-1:0]    found;
    logic               overflow_int;
    logic [ADR_W-1:0]   slot_adr [NCLUSTERS];
    logic [CNT_W-1:0]   slot_cnt [NCLUSTERS];

    logic [NVPF-1:0]    mask_in;

    logic [PAD_W-1:0]   mask_pad;
    logic [GRP_W-1:0]   grp      [NGRP];
    logic [NGRP-1:0]    grp_any;
    logic [GSEL_W-1:0]  grp_sel;
    logic [GRP_W-1:0]   grp_bits;
    logic [3:0]         bit_sel;
    logic               hit;
    logic [ADR_W-1:0]   first_idx;
    logic [NVPF-1:0]    first_onehot;
    logic [NVPF-1:0]    mask_clr;

`ifdef TRUNCATE_CLUSTERS_EN
    // Keep only the leading pad of each run; bit 0 has no lower neighbour
    // so the shifted-in zero leaves it unchanged.
    assign mask_in = bus.vpfs & ~(bus.vpfs << 1);
`else
    assign mask_in = bus.vpfs;
`endif

    // Split the working mask into 16-bit groups and flag non-empty groups.
    always_comb begin
        mask_pad = '0;
        mask_pad[NVPF-1:0] = mask;
        for (int g = 0; g < NGRP; g++) begin
            grp[g]     = mask_pad[g*GRP_W +: GRP_W];
            grp_any[g] = |grp[g];
        end
    end

    // Pick the lowest non-empty group (scan high to low, last hit wins).
    always_comb begin
        grp_sel = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (grp_any[g]) begin
                grp_sel = GSEL_W'(g);
            end
        end
    end

    // Lowest set bit inside the selected group gives the full address.
    always_comb begin
        grp_bits = grp[grp_sel];
        bit_sel  = '0;
        for (int b = GRP_W - 1; b >= 0; b--) begin
            if (grp_bits[b]) begin
                bit_sel = 4'(b);
            end
        end
        hit       = |grp_any;
        first_idx = ADR_W'({grp_sel, bit_sel});
    end

    // Mask with the extracted bit removed, for the next slot.
    always_comb begin
        first_onehot = '0;
        if (hit) begin
            first_onehot[first_idx] = 1'b1;
        end
        mask_clr = mask & ~first_onehot;
    end

    // Per-pad cluster counts, captured on every start strobe.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < NVPF; i++) begin
                cnt_lat[i] <= '0;
            end
        end else if (bus.start) begin
            for (int i = 0; i < NVPF; i++) begin
                cnt_lat[i] <= bus.cnts[i*CNT_W +: CNT_W];
            end
        end
    end

    // Frame FSM: latch on start, extract one slot per cycle, publish at once.
    // A start in any state (re)starts a frame; in PUBLISH the completing
    // frame is still published on that same edge.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state        <= IDLE;
            mask         <= '0;
            k            <= '0;
            found        <= '0;
            overflow_int <= 1'b0;
            for (int j = 0; j < NCLUSTERS; j++) begin
                slot_adr[j] <= INVALID;
                slot_cnt[j] <= '0;
            end
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.adr      <= '1;
            bus.cnt      <= '0;
            bus.nfound   <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                SEARCH: begin
                    slot_adr[k] <= hit ? first_idx : INVALID;
                    slot_cnt[k] <= hit ? cnt_lat[first_idx] : '0;
                    mask        <= mask_clr;
                    if (hit) begin
                        found <= found + 1'b1;
                    end
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        overflow_int <= |mask_clr;
                        state        <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    for (int j = 0; j < NCLUSTERS; j++) begin
                        bus.adr[j*ADR_W +: ADR_W] <= slot_adr[j];
                        bus.cnt[j*CNT_W +: CNT_W] <= slot_cnt[j];
                    end
                    bus.nfound   <= found;
                    bus.overflow <= overflow_int;
                    bus.valid    <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                end
            endcase
            if (bus.start) begin
                mask         <= mask_in;
                k            <= '0;
                found        <= '0;
                overflow_int <= 1'b0;
                bus.busy     <= 1'b1;
                state        <= SEARCH;
            end
        end
    end
endmodule

// File: tb/tb_first_n_of_w.sv
// Testbench for first_n_of_w: directed frames plus randomized frames, each
// checked against a reference that scans the flag vector in address order.
module tb_first_n_of_w;
    localparam int NVPF  = 1536;
    localparam int NCL   = 8;
    localparam int CNT_W = 3;
    localparam int ADR_W = 11;
    localparam int INV   = (1 << ADR_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    first_n_of_w_if #(.NVPF(NVPF), .NCLUSTERS(NCL), .CNT_W(CNT_W), .ADR_W(ADR_W)) bus ();

    first_n_of_w #(.NVPF(NVPF), .NCLUSTERS(NCL), .CNT_W(CNT_W), .ADR_W(ADR_W)) dut (
        .clock4x        (clk),
        .global_reset_n (rst_n),
        .bus            (bus)
    );

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [NVPF-1:0]       tb_vpfs;
    logic [NVPF*CNT_W-1:0] tb_cnts;
    int exp_adr [NCL];
    int exp_cnt [NCL];
    int exp_n;
    int exp_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk addresses upwards, keep the first NCL hits.
    task automatic model();
        int n;
        n       = 0;
        exp_ovf = 0;
        for (int s = 0; s < NCL; s++) begin
            exp_adr[s] = INV;
            exp_cnt[s] = 0;
        end
        for (int i = 0; i < NVPF; i++) begin
            bit h;
            h = tb_vpfs[i];
`ifdef TRUNCATE_CLUSTERS_EN
            if (i > 0 && tb_vpfs[i-1]) h = 1'b0;
`endif
            if (h) begin
                if (n < NCL) begin
                    exp_adr[n] = i;
                    exp_cnt[n] = int'(tb_cnts[i*CNT_W +: CNT_W]);
                    n++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
        exp_n = n;
    endtask

    task automatic clear_frame();
        tb_vpfs = '0;
        for (int i = 0; i < NVPF; i++) tb_cnts[i*CNT_W +: CNT_W] = CNT_W'($urandom);
    endtask

    task automatic put(input int a, input int c);
        tb_vpfs[a] = 1'b1;
        tb_cnts[a*CNT_W +: CNT_W] = CNT_W'(c);
    endtask

    task automatic check_outputs(input string tag);
        for (int s = 0; s < NCL; s++) begin
            check($sformatf("%s.adr%0d", tag, s), 64'(bus.adr[s*ADR_W +: ADR_W]), 64'(exp_adr[s]));
            check($sformatf("%s.cnt%0d", tag, s), 64'(bus.cnt[s*CNT_W +: CNT_W]), 64'(exp_cnt[s]));
        end
        check({tag, ".nfound"}, 64'(bus.nfound), 64'(exp_n));
        check({tag, ".overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"}, 64'(bus.busy), 0);
        check({tag, ".valid"}, 64'(bus.valid), 0);
        check({tag, ".nfound"}, 64'(bus.nfound), 0);
        check({tag, ".overflow"}, 64'(bus.overflow), 0);
        for (int s = 0; s < NCL; s++)
            check($sformatf("%s.adr%0d", tag, s), 64'(bus.adr[s*ADR_W +: ADR_W]), 64'(INV));
        check({tag, ".cnt"}, 64'(bus.cnt), 0);
    endtask

    // Start pulse on the next rising edge; se is that edge's number.
    task automatic launch(output int se);
        @(negedge clk);
        bus.vpfs  = tb_vpfs;
        bus.cnts  = tb_cnts;
        bus.start = 1'b1;
        se = edge_no;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at the observation point right after edge se.
    task automatic await_valid(input int se, input string tag);
        int seen;
        seen = -1;
        check({tag, ".busy"}, 64'(bus.busy), 1);
        for (int n = 1; n <= 40 && seen < 0; n++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen = edge_no - 1;
        end
        check({tag, ".latency"}, 64'(seen - se), 64'(NCL + 1));
        if (seen >= 0) begin
            check({tag, ".busy_at_valid"}, 64'(bus.busy), 0);
            check_outputs(tag);
        end
    endtask

    task automatic run_frame(input string tag);
        int se;
        model();
        launch(se);
        await_valid(se, tag);
        @(negedge clk);
        check({tag, ".pulse"}, 64'(bus.valid), 0);
        repeat (2) @(negedge clk);
        check({tag, ".hold_nfound"}, 64'(bus.nfound), 64'(exp_n));
        check({tag, ".hold_adr0"}, 64'(bus.adr[ADR_W-1:0]), 64'(exp_adr[0]));
    endtask

    initial begin
        int se1, se2, vseen;
        bus.start = 1'b0;
        bus.vpfs  = '0;
        bus.cnts  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        clear_frame(); put(5, 3); put(100, 1); put(1535, 7);
        run_frame("three");

        clear_frame();
        for (int i = 0; i < 10; i++) put(i, i + 1);
        run_frame("run10");

        clear_frame();
        run_frame("zero");

        clear_frame();
        put(0, 2); put(17, 4); put(200, 6); put(777, 1);
        put(1000, 5); put(1200, 3); put(1400, 7); put(1535, 1);
        run_frame("exact8");

        // Restart while searching: only the second frame is published.
        clear_frame(); put(10, 2);
        launch(se1);
        repeat (3) @(negedge clk);
        clear_frame(); put(20, 5);
        model();
        bus.vpfs  = tb_vpfs;
        bus.cnts  = tb_cnts;
        bus.start = 1'b1;
        se2 = edge_no;
        check("abort.offset", 64'(se2 - se1), 4);
        @(negedge clk);
        bus.start = 1'b0;
        await_valid(se2, "abort");

        // Start in the PUBLISH cycle: old frame still published, new one runs.
        clear_frame(); put(33, 6); put(34, 2); put(900, 4);
        model();
        launch(se1);
        repeat (8) @(negedge clk);
        check("pub.prevalid", 64'(bus.valid), 0);
        clear_frame(); put(64, 3); put(1100, 5);
        bus.vpfs  = tb_vpfs;
        bus.cnts  = tb_cnts;
        bus.start = 1'b1;
        se2 = edge_no;
        @(negedge clk);
        bus.start = 1'b0;
        check("pubA.valid", 64'(bus.valid), 1);
        check_outputs("pubA");
        model();
        await_valid(se2, "pubB");

        // Reset in the middle of a frame.
        clear_frame(); put(300, 2);
        launch(se1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        vseen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.valid === 1'b1) vseen++;
        end
        check("midrst.novalid", 64'(vseen), 0);
        clear_frame(); put(42, 6); put(43, 1); put(1534, 3);
        run_frame("after_rst");

        // Randomized frames of varying density.
        for (int f = 0; f < 25; f++) begin
            int mode;
            clear_frame();
            mode = $urandom_range(0, 3);
            case (mode)
                0: for (int j = 0; j < int'($urandom_range(0, 6)); j++)
                       tb_vpfs[$urandom_range(0, NVPF - 1)] = 1'b1;
                1: for (int j = 0; j < 8; j++)
                       tb_vpfs[$urandom_range(0, NVPF - 1)] = 1'b1;
                2: for (int j = 0; j < int'($urandom_range(20, 40)); j++)
                       tb_vpfs[$urandom_range(0, NVPF - 1)] = 1'b1;
                default: for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                       int b, l;
                       b = $urandom_range(0, NVPF - 8);
                       l = $urandom_range(1, 7);
                       for (int m = 0; m < l; m++) tb_vpfs[b + m] = 1'b1;
                   end
            endcase
            if ($urandom_range(0, 4) == 0) tb_vpfs[NVPF - 1] = 1'b1;
            if ($urandom_range(0, 4) == 0) tb_vpfs[0] = 1'b1;
            run_frame($sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
